// File: rtl/alert_fusion_controller.sv
// Fire-alert fusion: synchronizes and debounces the FFT and camera flags,
// corroborates them within a window, then holds the alert until acknowledged.
module alert_fusion_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WINDOW_CYCLES   = 1024,
    parameter int HOLD_CYCLES     = 4096,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fft_flag_in,
    input  logic       cam_flag_in,
    input  logic       ack_in,
    output logic       final_alert_out,
    output logic       fft_debug,
    output logic       cam_debug,
    output logic [1:0] state_out,
    output logic [7:0] alert_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FFT_PEND = 2'd1,
        CAM_PEND = 2'd2,
        ALERT    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    // Bit 0 carries the FFT flag, bit 1 the camera flag.
    logic [1:0]       sync1, sync2;
    logic             ack_s1, ack_s2;
    logic [1:0]       db, db_prev;
    logic [CNT_W-1:0] db_cnt [2];
    logic [1:0]       rise;

    state_t           state, next;
    logic [CNT_W-1:0] win_cnt, hold_cnt;
    logic             win_last, hold_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            ack_s1  <= 1'b0;
            ack_s2  <= 1'b0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= {cam_flag_in, fft_flag_in};
            sync2   <= sync1;
            ack_s1  <= ack_in;
            ack_s2  <= ack_s1;
            db_prev <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise      = db & ~db_prev;
    assign win_last  = (win_cnt == WIN_LAST);
    assign hold_done = (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            win_cnt     <= '0;
            hold_cnt    <= '0;
            alert_count <= '0;
        end else begin
            state <= next;
            if (next == state && (state == FFT_PEND || state == CAM_PEND))
                win_cnt <= win_cnt + 1'b1;
            else
                win_cnt <= '0;
            if (state == ALERT && next == ALERT)
                hold_cnt <= hold_done ? hold_cnt : hold_cnt + 1'b1;
            else
                hold_cnt <= '0;
            if (next == ALERT && state != ALERT && alert_count != 8'hFF)
                alert_count <= alert_count + 1'b1;
        end
    end

    // Corroboration is checked before window expiry in the pending states.
    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (&db)          next = ALERT;
                else if (rise[0]) next = FFT_PEND;
                else if (rise[1]) next = CAM_PEND;
            end
            FFT_PEND: begin
                if (db[1])         next = ALERT;
                else if (win_last) next = IDLE;
            end
            CAM_PEND: begin
                if (db[0])         next = ALERT;
                else if (win_last) next = IDLE;
            end
            ALERT: begin
                if (hold_done && ack_s2 && db == 2'b00) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        final_alert_out = (state == ALERT);
        state_out       = state;
        fft_debug       = db[0];
        cam_debug       = db[1];
    end

endmodule

// File: doc/alert_fusion_controller.md
Name: alert_fusion_controller

Overview:
Sequencing controller for the fire-alert path. Synchronizes and debounces the FFT flag (ESP32) and camera flag (Pi). Declares an alert only when both detectors corroborate within a bounded time window. Holds the alert for a minimum time and releases it only on an acknowledge from the ESP32 once both flags are quiet.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced flag changes (>=1)
WINDOW_CYCLES, 1024, corroboration window length in clocks after the first single-detector rising edge (>=1)
HOLD_CYCLES, 4096, minimum clocks final_alert_out stays high (>=1)
CNT_W, 16, width of the internal counters; all cycle parameters must fit in CNT_W

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
fft_flag_in  input  1  asynchronous FFT detection flag from ESP32
cam_flag_in  input  1  asynchronous camera detection flag from Pi
ack_in  input  1  asynchronous alert acknowledge from ESP32, level
final_alert_out  output  1  fused alert to ESP32
fft_debug  output  1  debounced FFT flag
cam_debug  output  1  debounced camera flag
state_out  output  2  FSM state: 0 IDLE, 1 FFT_PEND, 2 CAM_PEND, 3 ALERT
alert_count  output  8  number of ALERT entries since reset, saturating at 255

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (reset_n). While reset_n=0, all flops clear immediately: sync stages, debounced flags, counters, state=IDLE, and all outputs 0. This applies mid-operation, including during ALERT.
- Synchronizers: each of fft_flag_in, cam_flag_in, and ack_in passes through a 2-flop synchronizer. ack is not debounced.
- Debounce, per flag:
  - Counter increments each cycle the synced value differs from the debounced value; it clears when they are equal.
  - When the counter is DEBOUNCE_CYCLES-1 and the values still differ, the debounced value toggles on the next edge and the counter clears.
  - A clean step appears on *_debug DEBOUNCE_CYCLES+2 clocks after the first edge that samples it.
  - Glitches shorter than DEBOUNCE_CYCLES synced cycles are suppressed.
- Rising edge: debounced value is 1 now and was 0 the previous cycle.
- FSM (registered; outputs are Moore, decoded from state):
  - IDLE:
    - both debounced levels 1 -> ALERT (this covers simultaneous rising edges);
    - else fft rising edge -> FFT_PEND;
    - else cam rising edge -> CAM_PEND.
    - A flag that stays high after a window expiry does not re-enter PEND without a new rising edge.
  - FFT_PEND / CAM_PEND:
    - window counter is cleared on entry and increments each cycle;
    - the other debounced flag at 1 in any PEND cycle -> ALERT;
    - corroboration takes priority over expiry;
    - counter == WINDOW_CYCLES-1 without corroboration -> IDLE, so PEND lasts exactly WINDOW_CYCLES cycles.
    - If the pending flag itself drops, the window still runs to completion.
  - ALERT:
    - hold counter is cleared on entry and increments, saturating at HOLD_CYCLES;
    - exit to IDLE requires all of: hold_done (counter == HOLD_CYCLES), synced ack=1, and both debounced flags=0.
    - ack asserted before hold_done is ignored; it must still be high when the other conditions are met.
- final_alert_out = (state==ALERT). It rises on the same edge the state becomes ALERT, so there is no extra latency beyond the FSM transition.
- alert_count increments on every transition into ALERT and saturates at 255.
- state_out reflects the current registered state.

Test Plan:
(Benches use DEBOUNCE_CYCLES=4, WINDOW_CYCLES=20, HOLD_CYCLES=50.)
- fft_flag_in pulses high for 3 clocks -> fft_debug stays 0, state_out stays 0. Holding fft high -> fft_debug rises exactly 6 clocks after the first sampling edge.
- fft high; cam rises so that cam_debug goes high 10 cycles into FFT_PEND -> state_out 1->3, final_alert_out=1, alert_count=1.
- fft high only -> FFT_PEND for exactly 20 cycles then IDLE, final_alert_out stays 0. cam rising afterwards -> ALERT (both levels high in IDLE).
- Both flags rise on the same clock -> IDLE goes directly to ALERT; state_out never shows 1 or 2.
- In ALERT: ack held high from cycle 5 with flags cleared -> alert persists until cycle 50 (hold_done), then IDLE. ack high with cam still high -> stays ALERT.
- reset_n pulled low during ALERT -> final_alert_out, state_out, and alert_count drop to 0 asynchronously; after release the FSM is in IDLE.
